// File: rtl/uart_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// uart_frame_buffer_if
// Byte stream handshake between the frame buffer and the bootstrap consumer.
//   out_valid : producer -> consumer, out_data holds a payload byte
//   out_ready : consumer -> producer, byte accepted when out_valid && out_ready
//   out_data  : producer -> consumer, payload byte
//   out_last  : producer -> consumer, marks the final payload byte of a frame
// Modports: master = frame buffer (producer), slave = consumer.
// -----------------------------------------------------------------------------
interface uart_frame_buffer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/uart_frame_buffer.sv
// -----------------------------------------------------------------------------
// uart_frame_buffer
// Captures NUM_PACKETS-byte frames from the UART receiver into block RAM,
// verifies that the 8-bit sum of all bytes (checksum byte included) is zero,
// then replays bytes 0..NUM_PACKETS-2 over a valid/ready stream.
// Ports:
//   clk, n_rst      : clock, asynchronous active-low reset
//   packet_en/data  : received byte strobe and value
//   packet_count    : receiver's index of the current byte
//   buffer_finish   : marks the last byte of a frame
//   timeout         : receiver saw the line idle (level)
//   out_if          : payload stream (master side)
//   frame_ok        : one-cycle pulse per verified frame
//   frame_count     : number of verified frames since reset (wraps)
//   session_done    : clean end of session (level)
//   frame_err       : sticky protocol/checksum/overrun error
// -----------------------------------------------------------------------------
module uart_frame_buffer #(
  parameter int NUM_PACKETS = 256,
  parameter int COUNT_BITS  = 16
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           packet_en,
  input  logic [7:0]                     data,
  input  logic [$clog2(NUM_PACKETS)-1:0] packet_count,
  input  logic                           buffer_finish,
  input  logic                           timeout,
  uart_frame_buffer_if.master            out_if,
  output logic                           frame_ok,
  output logic [COUNT_BITS-1:0]          frame_count,
  output logic                           session_done,
  output logic                           frame_err
);
  localparam int AW = $clog2(NUM_PACKETS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_PACKETS - 1);
  localparam logic [AW-1:0] LAST_OUT = AW'(NUM_PACKETS - 2);

  typedef enum logic [2:0] {FILL, CHECK, DRAIN, ERROR, DONE} state_t;

  logic [7:0]            mem [NUM_PACKETS];
  logic [7:0]            ram_q;
  state_t                state_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [7:0]            sum_q;
  logic [7:0]            sum_d;
  logic                  rv_q;        // ram_q holds a byte not yet forwarded
  logic                  rlast_q;     // that byte is the final payload byte
  logic                  out_valid_q;
  logic [7:0]            out_data_q;
  logic                  out_last_q;
  logic                  frame_ok_q;
  logic [COUNT_BITS-1:0] frame_count_q;
  logic                  session_done_q;
  logic                  frame_err_q;

  logic wr_en;
  logic rd_en;
  logic out_free;
  logic out_hs;
  logic advance;
  logic rd_pending;

  assign sum_d      = sum_q + data;
  assign out_free   = !out_valid_q || out_if.out_ready;
  assign out_hs     = out_valid_q && out_if.out_ready;
  assign advance    = rv_q && out_free;
  assign rd_pending = (rd_ptr_q != LAST_IDX);
  assign wr_en      = (state_q == FILL) && packet_en;
  // The first read is issued during CHECK so byte 0 reaches the output
  // register two cycles later. In DRAIN a read is issued whenever the RAM
  // output register is empty or is being forwarded this cycle; ram_q itself
  // is the skid entry that holds a read-ahead byte while the consumer stalls.
  assign rd_en      = (state_q == CHECK) ||
                      ((state_q == DRAIN) && rd_pending && (!rv_q || out_free));

  // Frame storage: write port from the receiver, registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= data;
    if (rd_en) ram_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= FILL;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      sum_q          <= '0;
      rv_q           <= 1'b0;
      rlast_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_last_q     <= 1'b0;
      frame_ok_q     <= 1'b0;
      frame_count_q  <= '0;
      session_done_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      frame_ok_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (packet_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            sum_q    <= sum_d;
            if (packet_count != wr_ptr_q) begin
              state_q     <= ERROR;
              frame_err_q <= 1'b1;
            end else if (wr_ptr_q == LAST_IDX) begin
              if (buffer_finish) begin
                state_q <= CHECK;
              end else begin
                state_q     <= ERROR;
                frame_err_q <= 1'b1;
              end
            end else if (buffer_finish) begin
              state_q     <= ERROR;
              frame_err_q <= 1'b1;
            end
          end else if (timeout) begin
            if (wr_ptr_q == '0) begin
              state_q        <= DONE;
              session_done_q <= 1'b1;
            end else begin
              state_q     <= ERROR;
              frame_err_q <= 1'b1;
            end
          end
        end

        CHECK: begin
          if (packet_en || (sum_q != 8'd0)) begin
            state_q     <= ERROR;
            frame_err_q <= 1'b1;
          end else begin
            state_q       <= DRAIN;
            frame_ok_q    <= 1'b1;
            frame_count_q <= frame_count_q + 1'b1;
            rd_ptr_q      <= rd_ptr_q + 1'b1;
            rv_q          <= 1'b1;
            rlast_q       <= (rd_ptr_q == LAST_OUT);
          end
        end

        DRAIN: begin
          if (packet_en) begin
            state_q     <= ERROR;
            frame_err_q <= 1'b1;
            out_valid_q <= 1'b0;
            rv_q        <= 1'b0;
          end else begin
            if (advance) begin
              out_valid_q <= 1'b1;
              out_data_q  <= ram_q;
              out_last_q  <= rlast_q;
            end else if (out_hs) begin
              out_valid_q <= 1'b0;
            end

            if (rd_en) begin
              rd_ptr_q <= rd_ptr_q + 1'b1;
              rv_q     <= 1'b1;
              rlast_q  <= (rd_ptr_q == LAST_OUT);
            end else if (advance) begin
              rv_q <= 1'b0;
            end

            // Final payload byte accepted: the buffer is free for the next
            // frame, or the session ends if the receiver already timed out.
            if (out_hs && out_last_q) begin
              out_valid_q    <= 1'b0;
              out_last_q     <= 1'b0;
              rv_q           <= 1'b0;
              rd_ptr_q       <= '0;
              wr_ptr_q       <= '0;
              sum_q          <= '0;
              state_q        <= timeout ? DONE : FILL;
              session_done_q <= timeout;
            end
          end
        end

        default: begin
          // ERROR and DONE are terminal until reset.
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;
  assign frame_ok         = frame_ok_q;
  assign frame_count      = frame_count_q;
  assign session_done     = session_done_q;
  assign frame_err        = frame_err_q;
endmodule
